grant_bus_mux: RTL and testbench

//  Consumer of the 4-way arbiter's one-hot grant. Latches the granted requester as bus owner,

---
 rtl/grant_bus_mux.sv | 178 +++++++++++++++++
 tb/tb_grant_bus_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : grant_bus_mux
//  Purpose  : Bus-owner latch and beat forwarder behind a 4-way arbiter.
//             Takes the one-hot grant, latches the granted requester as owner,
//             forwards its beats through one registered output stage to a
//             single slave, and pulses done[owner] once the burst has fully
//             left the output register.
//  Ports    : clk, res_n              clock, async active-low reset
//             grant[3:0]              one-hot grant from arbiter
//             m_valid/m_data/m_last   per-requester beat inputs
//             m_ready[3:0]            per-requester accept (at most one high)
//             done[3:0]               one-cycle end-of-burst pulse to owner
//             s_valid/s_data/s_owner/s_last, s_ready   slave side
//             err_grant               sticky grant protocol error
//  Revision : 1.0  initial release
// ============================================================================
module grant_bus_mux #(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic [3:0]      grant,
    input  logic [3:0]      m_valid,
    input  logic [4*DW-1:0] m_data,
    input  logic [3:0]      m_last,
    output logic [3:0]      m_ready,
    output logic [3:0]      done,
    output logic            s_valid,
    output logic [DW-1:0]   s_data,
    output logic [1:0]      s_owner,
    output logic            s_last,
    input  logic            s_ready,
    output logic            err_grant
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] C_LAST_CNT = CW'(MAX_BEATS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_XFER    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q;
    logic [CW-1:0] cnt_q;
    logic          s_valid_q;
    logic [DW-1:0] s_data_q;
    logic [1:0]    s_owner_q;
    logic          s_last_q;
    logic          err_q;

    logic [DW-1:0] req_data [4];
    logic          grant_onehot;
    logic          grant_multi;
    logic [1:0]    grant_idx;
    logic          out_free;
    logic          beat_acc;
    logic          beat_end;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign req_data[gi] = m_data[gi*DW +: DW];
        end
    endgenerate

    // Power-of-two test: a non-zero vector with a single bit set.
    assign grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    assign grant_multi  = (grant != 4'b0000) && !grant_onehot;

    always_comb begin
        grant_idx = 2'd0;
        case (grant)
            4'b0010: grant_idx = 2'd1;
            4'b0100: grant_idx = 2'd2;
            4'b1000: grant_idx = 2'd3;
            default: grant_idx = 2'd0;
        endcase
    end

    // The output register can take a new beat when it is empty or being
    // emptied this cycle; this gives 1 beat/clk with s_ready held high.
    assign out_free = !s_valid_q || s_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_onehot)     state_d = ST_XFER;
            ST_XFER:    if (beat_end)         state_d = ST_DRAIN;
            ST_DRAIN:   if (out_free)         state_d = ST_RELEASE;
            ST_RELEASE: if (!grant[owner_q])  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        m_ready  = 4'b0000;
        done     = 4'b0000;
        beat_acc = 1'b0;
        beat_end = 1'b0;
        case (state_q)
            ST_XFER: begin
                m_ready[owner_q] = out_free;
                beat_acc         = m_valid[owner_q] && out_free;
                beat_end         = beat_acc && (m_last[owner_q] || (cnt_q == C_LAST_CNT));
            end
            ST_DRAIN: begin
                done[owner_q] = out_free;
            end
            default: begin
                m_ready  = 4'b0000;
                done     = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------- owner and beat count
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            owner_q <= 2'd0;
            cnt_q   <= '0;
        end else if ((state_q == ST_IDLE) && grant_onehot) begin
            owner_q <= grant_idx;
            cnt_q   <= '0;
        end else if (beat_acc) begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------ registered output stage
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_owner_q <= 2'd0;
            s_last_q  <= 1'b0;
        end else if (beat_acc) begin
            s_valid_q <= 1'b1;
            s_data_q  <= req_data[owner_q];
            s_owner_q <= owner_q;
            s_last_q  <= beat_end;
        end else if (s_valid_q && s_ready) begin
            s_valid_q <= 1'b0;
        end
    end

    // ---------------------------------------------------- sticky grant error
    // The owner's grant must stay up until RELEASE; routing ignores it anyway.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            err_q <= 1'b0;
        end else if (((state_q == ST_IDLE) && grant_multi) ||
                     (((state_q == ST_XFER) || (state_q == ST_DRAIN)) && !grant[owner_q])) begin
            err_q <= 1'b1;
        end
    end

    assign s_valid   = s_valid_q;
    assign s_data    = s_data_q;
    assign s_owner   = s_owner_q;
    assign s_last    = s_last_q;
    assign err_grant = err_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grant_bus_mux
//  Purpose  : Self-checking bench for grant_bus_mux. Directed reset, grant
//             error and async-reset cases, then randomized bursts driven by
//             a behavioural arbiter and requesters, checked against a
//             transaction-level model of which beats each grant must carry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_grant_bus_mux;

    localparam int DW  = 8;
    localparam int MB  = 16;
    localparam int NB  = 60;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            res_n;
    logic [3:0]      grant;
    logic [3:0]      m_valid;
    logic [4*DW-1:0] m_data;
    logic [3:0]      m_last;
    logic [3:0]      m_ready;
    logic [3:0]      done;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic [1:0]      s_owner;
    logic            s_last;
    logic            s_ready;
    logic            err_grant;

    grant_bus_mux #(.DW(DW), .MAX_BEATS(MB)) u_dut (
        .clk       (clk),
        .res_n     (res_n),
        .grant     (grant),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .done      (done),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_owner   (s_owner),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .err_grant (err_grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-requester beat streams; the head is what the requester presents.
    beat_t strm [4][$];
    beat_t exp_q[$];

    // A stream holds a complete burst once it has a last flag within the
    // first MB beats or at least MB beats (the cap ends it).
    function automatic bit burst_ready(input int o);
        for (int i = 0; i < strm[o].size() && i < MB; i++)
            if (strm[o][i].l) return 1'b1;
        return strm[o].size() >= MB;
    endfunction

    task automatic fill(input int o);
        while (!burst_ready(o)) begin
            int  len;
            bit  nolast;
            nolast = ($urandom_range(0, 3) == 0);
            len    = nolast ? 20 : int'($urandom_range(1, 20));
            for (int j = 0; j < len; j++) begin
                beat_t b;
                b.d = DW'($urandom);
                b.l = !nolast && (j == len - 1);
                strm[o].push_back(b);
            end
        end
    endtask

    // Beats carried by one grant: up to and including the first last flag,
    // never more than MB.
    function automatic int burst_len(input int o);
        for (int i = 0; i < strm[o].size(); i++)
            if (strm[o][i].l || i == MB - 1) return i + 1;
        return strm[o].size();
    endfunction

    initial begin
        int   owner, k, acc, del, gnt_age, phase, hold, gap, bursts_done, cyc;
        bit   burst_on, done_seen, exp_sv, xfer, exp_done;
        logic [3:0] exp_mr, m_hs, grant_n, mv_n, ml_n;
        logic [4*DW-1:0] md_n;
        logic sr_n;

        res_n = 1'b0; grant = 4'b0; m_valid = 4'b0; m_data = '0; m_last = 4'b0; s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 res_n = 1'b1;

        // Idle after reset: nothing moves with no grant.
        repeat (10) begin
            @(negedge clk);
            chk("idle_m_ready", m_ready, 4'b0);
            chk("idle_done", done, 4'b0);
            chk("idle_s_valid", s_valid, 1'b0);
            chk("idle_err", err_grant, 1'b0);
        end

        // Multi-bit grant in IDLE: sticky error, no owner taken.
        @(posedge clk); #1 grant = 4'b0011; m_valid = 4'b0011;
        @(posedge clk); #1 grant = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("multi_err", err_grant, 1'b1);
            chk("multi_m_ready", m_ready, 4'b0);
        end

        // Still in IDLE, so a clean grant is taken; then async reset mid-XFER.
        @(posedge clk); #1 grant = 4'b0001; m_valid = 4'b0001; m_data = {24'h0, 8'h5A}; s_ready = 1'b0;
        @(negedge clk);
        chk("lat_m_ready_n0", m_ready, 4'b0);
        @(negedge clk);
        chk("lat_m_ready_n1", m_ready, 4'b0001);
        @(negedge clk);
        chk("xfer_s_valid", s_valid, 1'b1);
        chk("xfer_s_data", s_data, 8'h5A);
        chk("xfer_stall_m_ready", m_ready, 4'b0);
        #2 res_n = 1'b0;
        #1;
        chk("rst_m_ready", m_ready, 4'b0);
        chk("rst_done", done, 4'b0);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_s_data", s_data, 8'h00);
        chk("rst_s_owner", s_owner, 2'd0);
        chk("rst_s_last", s_last, 1'b0);
        chk("rst_err", err_grant, 1'b0);
        grant = 4'b0; m_valid = 4'b0; m_data = '0;
        @(posedge clk); #1 res_n = 1'b1;

        // Randomized bursts.
        for (int i = 0; i < 4; i++) strm[i].delete();
        exp_q.delete();
        owner = 0; k = 0; acc = 0; del = 0; gnt_age = 0; burst_on = 0; done_seen = 0;
        phase = 0; hold = 0; gap = 1; bursts_done = 0; cyc = 0;

        while (bursts_done < NB && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            grant_n = grant;
            exp_sv  = (acc != del);
            xfer    = burst_on && gnt_age >= 1 && acc < k;
            exp_mr  = xfer && (!exp_sv || s_ready) ? (4'b0001 << owner) : 4'b0000;
            exp_done = burst_on && !done_seen && acc == k &&
                       (del == k || (del == k - 1 && exp_sv && s_ready));
            chk("m_ready", m_ready, exp_mr);
            chk("s_valid", s_valid, exp_sv);
            chk("done", done, exp_done ? (4'b0001 << owner) : 4'b0000);

            m_hs = m_valid & m_ready;
            for (int i = 0; i < 4; i++) begin
                if (m_hs[i] && strm[i].size() > 0) begin
                    void'(strm[i].pop_front());
                    if (burst_on && i == owner) acc++;
                end
            end

            if (s_valid && s_ready) begin
                chk("s_beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("s_data", s_data, e.d);
                    chk("s_owner", s_owner, owner);
                    chk("s_last", s_last, exp_q.size() == 0);
                    del++;
                end
            end

            if (burst_on) gnt_age++;

            if (phase == 1 && exp_done) begin
                done_seen = 1;
                bursts_done++;
                phase = 2;
                hold  = $urandom_range(0, 2);
            end
            if (phase == 2) begin
                if (hold == 0) begin
                    grant_n  = 4'b0;
                    burst_on = 0;
                    phase    = 0;
                    gap      = $urandom_range(1, 3);
                end else begin
                    hold--;
                end
            end else if (phase == 0) begin
                gap--;
                if (gap <= 0) begin
                    owner = $urandom_range(0, 3);
                    fill(owner);
                    k = burst_len(owner);
                    exp_q.delete();
                    for (int j = 0; j < k; j++) exp_q.push_back(strm[owner][j]);
                    acc = 0; del = 0; gnt_age = 0; burst_on = 1; done_seen = 0;
                    grant_n = 4'b0001 << owner;
                    phase = 1;
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (strm[i].size() > 0 && $urandom_range(0, 3) != 0) begin
                    mv_n[i] = 1'b1;
                    md_n[i*DW +: DW] = strm[i][0].d;
                    ml_n[i] = strm[i][0].l;
                end else begin
                    mv_n[i] = 1'b0;
                    md_n[i*DW +: DW] = DW'($urandom);
                    ml_n[i] = 1'($urandom);
                end
            end
            sr_n = ($urandom_range(0, 3) != 0);

            @(posedge clk);
            #1;
            grant = grant_n; m_valid = mv_n; m_data = md_n; m_last = ml_n; s_ready = sr_n;
        end

        chk("bursts_in_budget", 32'(bursts_done >= NB), 32'd1);
        chk("final_err", err_grant, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
